// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit bundle: memory-side fetch handshake, execute redirect, and decode-side output.
// master = fetch unit, slave = surrounding memory/execute/decode environment.
interface inst_fetch_unit_if;
    localparam int unsigned XLEN = 32;

    logic            inst_start;
    logic            inst_ready;
    logic [XLEN-1:0] i_addr;
    logic [XLEN-1:0] inst;
    logic            inst_valid;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_inst;

    modport master (
        output inst_start, i_addr, out_valid, out_pc, out_inst,
        input  inst_ready, inst, inst_valid, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  inst_start, i_addr, out_valid, out_pc, out_inst,
        output inst_ready, inst, inst_valid, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Single-outstanding instruction fetch unit with a small in-order buffer toward decode.
// Define IFETCH_PREFETCH_EN for a 2-entry buffer (prefetch one ahead); default is 1 entry.
module inst_fetch_unit #(
    parameter logic [31:0] START_ADDR = 32'h0000_0000
) (
    input logic                clk,
    input logic                rst,
    inst_fetch_unit_if.master  fetch_io
);
`ifdef IFETCH_PREFETCH_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } entry_t;

    state_e           state_q, state_d;
    logic             discard_q, discard_d;
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  req_pc_q, req_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    entry_t           buf_q [DEPTH];
    entry_t           buf_d [DEPTH];

    logic issue;
    logic resp;
    logic push;
    logic pop;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state: redirect never changes state; a WAIT always ends on the response
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (issue)               state_d = S_WAIT;
            S_WAIT: if (fetch_io.inst_valid) state_d = S_IDLE;
        endcase
    end

    // FSM outputs: issue strobe and response acceptance
    always_comb begin
        issue = 1'b0;
        resp  = 1'b0;
        case (state_q)
            S_IDLE: issue = fetch_io.inst_ready && (cnt_q < CNT_W'(DEPTH))
                            && !fetch_io.redirect_valid && !rst;
            S_WAIT: resp  = fetch_io.inst_valid;
        endcase
    end

    assign push = resp && !discard_q && !fetch_io.redirect_valid;
    assign pop  = (cnt_q != '0) && fetch_io.out_ready;

    // Datapath next-state; redirect overrides issue, push and pop
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        discard_d  = discard_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;

        if (resp) discard_d = 1'b0;

        if (fetch_io.redirect_valid) begin
            fetch_pc_d = fetch_io.redirect_pc & ~XLEN'(3);
            cnt_d      = '0;
            if ((state_q == S_WAIT) && !fetch_io.inst_valid) discard_d = 1'b1;
        end else begin
            if (issue) begin
                req_pc_d   = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (pop) begin
                for (int unsigned i = 0; i + 1 < DEPTH; i++) buf_d[i] = buf_q[i + 1];
                cnt_d = cnt_q - CNT_W'(1);
            end
            // Write lands at the first free slot after any same-cycle pop shift
            if (push) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (CNT_W'(i) == cnt_d) begin
                        buf_d[i].pc   = req_pc_q;
                        buf_d[i].inst = fetch_io.inst;
                    end
                end
                cnt_d = cnt_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= START_ADDR;
            req_pc_q   <= '0;
            discard_q  <= 1'b0;
            cnt_q      <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) buf_q[i] <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            discard_q  <= discard_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
        end
    end

    assign fetch_io.inst_start = issue;
    assign fetch_io.i_addr     = fetch_pc_q;
    assign fetch_io.out_valid  = (cnt_q != '0);
    assign fetch_io.out_pc     = buf_q[0].pc;
    assign fetch_io.out_inst   = buf_q[0].inst;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_inst_fetch_unit;
`ifdef IFETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [31:0] START = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_fetch_unit_if bus ();
    inst_fetch_unit #(.START_ADDR(START)) dut (.clk(clk), .rst(rst), .fetch_io(bus));

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    // Model: PC, outstanding flag, drop flag, and the decode buffer as a queue
    ent_t        q[$];
    logic [31:0] m_pc = START;
    logic [31:0] m_req = '0;
    bit          m_busy = 0;
    bit          m_drop = 0;

    // Memory responder
    int          lat_q = 0;
    logic [31:0] lat_data = '0;
    int          resp_lat = 2;
    bit          rand_lat = 0;
    bit          rand_data = 0;
    bit          spur_en = 0;
    logic [31:0] fixed_data = 32'h0000_0013;

    logic        obs_start, obs_ov, exp_start, exp_ov;
    logic [31:0] obs_addr, obs_opc, obs_oinst, exp_addr, exp_opc, exp_oinst;

    // One clock: drive at negedge, sample 1ns later, then advance model and responder
    task automatic run_cycle(input logic r, input logic ir, input logic rv,
                             input logic [31:0] rpc, input logic ordy);
        bit   resp_now;
        ent_t e;
        @(negedge clk);
        rst                = r;
        bus.inst_ready     = ir;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.out_ready      = ordy;
        resp_now           = (lat_q == 1);
        bus.inst_valid     = resp_now || (spur_en && !m_busy && ($urandom_range(0, 3) == 0));
        bus.inst           = resp_now ? lat_data : $urandom;
        #1;
        obs_start = bus.inst_start;
        obs_addr  = bus.i_addr;
        obs_ov    = bus.out_valid;
        obs_opc   = bus.out_pc;
        obs_oinst = bus.out_inst;

        if (r) begin
            exp_start = 1'b0; exp_addr = START; exp_ov = 1'b0; exp_opc = '0; exp_oinst = '0;
        end else begin
            exp_start = !m_busy && ir && (q.size() < DEPTH) && !rv;
            exp_addr  = m_pc;
            exp_ov    = (q.size() != 0);
            exp_opc   = exp_ov ? q[0].pc   : 32'hx;
            exp_oinst = exp_ov ? q[0].inst : 32'hx;
        end

        if (r) begin
            m_pc = START; m_busy = 0; m_drop = 0; q.delete();
        end else if (rv) begin
            q.delete();
            if (m_busy && bus.inst_valid) begin m_busy = 0; m_drop = 0; end
            else if (m_busy) m_drop = 1;
            m_pc = rpc & ~32'h3;
        end else begin
            if (exp_ov && ordy) void'(q.pop_front());
            if (m_busy && bus.inst_valid) begin
                if (!m_drop) begin e.pc = m_req; e.inst = bus.inst; q.push_back(e); end
                m_drop = 0;
                m_busy = 0;
            end
            if (exp_start) begin m_busy = 1; m_req = m_pc; m_pc = m_pc + 32'd4; end
        end

        if (resp_now) lat_q = 0;
        else if (lat_q > 1) lat_q--;
        if (exp_start) begin
            lat_q    = rand_lat ? int'($urandom_range(1, 4)) : resp_lat;
            lat_data = rand_data ? $urandom : fixed_data;
        end
    endtask

    task automatic do_reset();
        run_cycle(1, 0, 0, 32'h0, 0);
        run_cycle(1, 0, 0, 32'h0, 0);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            run_cycle(1, 1, 0, 32'h0, 1);
            n_vec++; if (obs_start !== 1'b0) begin n_err++; $display("FAIL reset_start got %b want 0", obs_start); end
            n_vec++; if (obs_ov !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", obs_ov); end
            n_vec++; if (obs_addr !== START) begin n_err++; $display("FAIL reset_i_addr got %h want %h", obs_addr, START); end
            n_vec++; if (obs_opc !== 32'h0) begin n_err++; $display("FAIL reset_out_pc got %h want 0", obs_opc); end
            n_vec++; if (obs_oinst !== 32'h0) begin n_err++; $display("FAIL reset_out_inst got %h want 0", obs_oinst); end
        end
    endtask

    task automatic test_sequential();
        logic [31:0] issued[$];
        bit          seen = 0;
        logic [31:0] f_pc = '0, f_inst = '0;
        logic [31:0] want;
        do_reset();
        resp_lat = 2;
        for (int c = 0; c < 16; c++) begin
            run_cycle(0, 1, 0, 32'h0, 1);
            if (obs_start) issued.push_back(obs_addr);
            if (!seen && obs_ov) begin seen = 1; f_pc = obs_opc; f_inst = obs_oinst; end
        end
        for (int k = 0; k < 3; k++) begin
            want = 32'(4 * k);
            n_vec++;
            if (k >= issued.size() || issued[k] !== want) begin
                n_err++; $display("FAIL seq_issue%0d got %h want %h", k, (k < issued.size()) ? issued[k] : 32'hx, want);
            end
        end
        n_vec++; if (!seen || f_pc !== 32'h0) begin n_err++; $display("FAIL seq_first_pc got %h want 0", f_pc); end
        n_vec++; if (!seen || f_inst !== 32'h13) begin n_err++; $display("FAIL seq_first_inst got %h want 00000013", f_inst); end
    endtask

    task automatic test_backpressure();
        logic [31:0] issued[$];
        logic [31:0] popped[$];
        logic [31:0] want;
        bit          got_new = 0;
        logic [31:0] new_addr = '0;
        do_reset();
        resp_lat = 2;
        for (int c = 0; c < 15; c++) begin
            run_cycle(0, 1, 0, 32'h0, 0);
            if (obs_start) issued.push_back(obs_addr);
        end
        n_vec++; if (issued.size() != DEPTH) begin n_err++; $display("FAIL bp_issue_count got %0d want %0d", issued.size(), DEPTH); end
        n_vec++; if (obs_start !== 1'b0) begin n_err++; $display("FAIL bp_stalled_start got %b want 0", obs_start); end
        for (int c = 0; c < 15; c++) begin
            run_cycle(0, 1, 0, 32'h0, 1);
            if (obs_ov) popped.push_back(obs_opc);
            if (!got_new && obs_start) begin got_new = 1; new_addr = obs_addr; end
        end
        for (int k = 0; k < DEPTH; k++) begin
            want = 32'(4 * k);
            n_vec++;
            if (k >= popped.size() || popped[k] !== want) begin
                n_err++; $display("FAIL bp_pop%0d got %h want %h", k, (k < popped.size()) ? popped[k] : 32'hx, want);
            end
        end
        n_vec++; if (!got_new || new_addr !== 32'(4 * DEPTH)) begin n_err++; $display("FAIL bp_resume got %h want %h", new_addr, 32'(4 * DEPTH)); end
    endtask

    task automatic test_redirect_wait();
        bit          hit = 0, saw4 = 0, got_new = 0;
        logic [31:0] new_addr = '0;
        logic        ov_after = 1'b1;
        do_reset();
        resp_lat = 3;
        for (int c = 0; c < 40 && !hit; c++) begin
            run_cycle(0, 1, 0, 32'h0, 1);
            if (obs_start && obs_addr == 32'h4) hit = 1;
        end
        n_vec++; if (!hit) begin n_err++; $display("FAIL rdw_no_issue_4 got none want 00000004"); end
        run_cycle(0, 1, 1, 32'h0000_0103, 1);
        for (int c = 0; c < 20; c++) begin
            run_cycle(0, 1, 0, 32'h0, 1);
            if (c == 0) ov_after = obs_ov;
            if (obs_ov && obs_opc == 32'h4) saw4 = 1;
            if (!got_new && obs_start) begin got_new = 1; new_addr = obs_addr; end
        end
        n_vec++; if (ov_after !== 1'b0) begin n_err++; $display("FAIL rdw_flush got %b want 0", ov_after); end
        n_vec++; if (saw4) begin n_err++; $display("FAIL rdw_drop got 1 want 0"); end
        n_vec++; if (!got_new || new_addr !== 32'h100) begin n_err++; $display("FAIL rdw_target got %h want 00000100", new_addr); end
    endtask

    task automatic test_redirect_same();
        bit          hit = 0, got_new = 0;
        logic [31:0] tgt, new_addr = '0;
        do_reset();
        resp_lat = 2;
        tgt = $urandom;
        for (int c = 0; c < 10 && !hit; c++) begin
            run_cycle(0, 1, 0, 32'h0, 1);
            if (obs_start) hit = 1;
        end
        run_cycle(0, 1, 0, 32'h0, 1);
        run_cycle(0, 1, 1, tgt, 1);
        n_vec++; if (bus.inst_valid !== 1'b1 || obs_start !== 1'b0) begin n_err++; $display("FAIL rds_setup got valid=%b start=%b want 1/0", bus.inst_valid, obs_start); end
        run_cycle(0, 1, 0, 32'h0, 1);
        n_vec++; if (obs_ov !== 1'b0) begin n_err++; $display("FAIL rds_not_pushed got %b want 0", obs_ov); end
        if (obs_start) begin got_new = 1; new_addr = obs_addr; end
        for (int c = 0; c < 5 && !got_new; c++) begin
            run_cycle(0, 1, 0, 32'h0, 1);
            if (obs_start) begin got_new = 1; new_addr = obs_addr; end
        end
        n_vec++; if (!got_new || new_addr !== {tgt[31:2], 2'b00}) begin n_err++; $display("FAIL rds_target got %h want %h", new_addr, {tgt[31:2], 2'b00}); end
    endtask

    task automatic test_wrap();
        logic [31:0] issued[$];
        do_reset();
        resp_lat = 1;
        run_cycle(0, 1, 1, 32'hFFFF_FFFE, 1);
        for (int c = 0; c < 12; c++) begin
            run_cycle(0, 1, 0, 32'h0, 1);
            if (obs_start) issued.push_back(obs_addr);
        end
        n_vec++; if (issued.size() < 1 || issued[0] !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_first got %h want fffffffc", (issued.size() > 0) ? issued[0] : 32'hx); end
        n_vec++; if (issued.size() < 2 || issued[1] !== 32'h0) begin n_err++; $display("FAIL wrap_second got %h want 00000000", (issued.size() > 1) ? issued[1] : 32'hx); end
    endtask

    task automatic test_inst_ready_low();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            run_cycle(0, 0, 0, 32'h0, 1);
            n_vec++; if (obs_start !== 1'b0) begin n_err++; $display("FAIL irl_start c%0d got %b want 0", c, obs_start); end
            n_vec++; if (obs_addr !== START) begin n_err++; $display("FAIL irl_addr c%0d got %h want %h", c, obs_addr, START); end
        end
        run_cycle(0, 1, 0, 32'h0, 1);
        n_vec++; if (obs_start !== 1'b1) begin n_err++; $display("FAIL irl_resume got %b want 1", obs_start); end
    endtask

    task automatic test_reset_mid_fetch();
        bit          got_new = 0;
        logic [31:0] new_addr = '0;
        do_reset();
        resp_lat = 3;
        run_cycle(0, 1, 0, 32'h0, 1);
        n_vec++; if (obs_start !== 1'b1) begin n_err++; $display("FAIL rmf_issue got %b want 1", obs_start); end
        for (int c = 0; c < 4; c++) begin
            run_cycle(1, 1, 0, 32'h0, 1);
            n_vec++; if (obs_ov !== 1'b0) begin n_err++; $display("FAIL rmf_ov_in_rst c%0d got %b want 0", c, obs_ov); end
        end
        run_cycle(0, 0, 0, 32'h0, 1);
        n_vec++; if (obs_ov !== 1'b0) begin n_err++; $display("FAIL rmf_ov_release got %b want 0", obs_ov); end
        for (int c = 0; c < 5 && !got_new; c++) begin
            run_cycle(0, 1, 0, 32'h0, 1);
            if (obs_start) begin got_new = 1; new_addr = obs_addr; end
        end
        n_vec++; if (!got_new || new_addr !== START) begin n_err++; $display("FAIL rmf_first got %h want %h", new_addr, START); end
    endtask

    task automatic test_random();
        logic        r, ir, rv, ordy;
        logic [31:0] rpc;
        do_reset();
        spur_en = 1; rand_lat = 1; rand_data = 1;
        for (int c = 0; c < 3000; c++) begin
            r    = ($urandom_range(0, 199) == 0);
            ir   = ($urandom_range(0, 3) != 0);
            rv   = ($urandom_range(0, 15) == 0);
            ordy = ($urandom_range(0, 4) < 3);
            rpc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            run_cycle(r, ir, rv, rpc, ordy);
            n_vec++; if (obs_start !== exp_start) begin n_err++; $display("FAIL rnd_start c%0d got %b want %b", c, obs_start, exp_start); end
            n_vec++; if (obs_addr !== exp_addr) begin n_err++; $display("FAIL rnd_i_addr c%0d got %h want %h", c, obs_addr, exp_addr); end
            n_vec++; if (obs_ov !== exp_ov) begin n_err++; $display("FAIL rnd_out_valid c%0d got %b want %b", c, obs_ov, exp_ov); end
            if (exp_ov) begin
                n_vec++; if (obs_opc !== exp_opc) begin n_err++; $display("FAIL rnd_out_pc c%0d got %h want %h", c, obs_opc, exp_opc); end
                n_vec++; if (obs_oinst !== exp_oinst) begin n_err++; $display("FAIL rnd_out_inst c%0d got %h want %h", c, obs_oinst, exp_oinst); end
            end
        end
        spur_en = 0; rand_lat = 0; rand_data = 0;
    endtask

    initial begin
        bus.inst_ready     = 1'b0;
        bus.inst           = '0;
        bus.inst_valid     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_same();
        test_wrap();
        test_inst_ready_low();
        test_reset_mid_fetch();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 Parameter: START_ADDR, 32'h00000000, PC of the first fetch after reset.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: inst_start  output  1  fetch request strobe to the memory interface.
REQ-005 Port: inst_ready  input  1  memory interface can accept a fetch this cycle.
REQ-006 Port: i_addr  output  32  fetch address; equals the internal fetch PC.
REQ-007 Port: inst  input  32  fetched instruction word.
REQ-008 Port: inst_valid  input  1  inst valid; sampled only while a fetch is outstanding.
REQ-009 Port: redirect_valid  input  1  branch/jump redirect strobe from execute.
REQ-010 Port: redirect_pc  input  32  redirect target; bits [1:0] are forced to zero.
REQ-011 Port: out_valid  output  1  head buffer entry valid to decode.
REQ-012 Port: out_ready  input  1  decode consumes the head entry.
REQ-013 Port: out_pc  output  32  PC of the head entry.
REQ-014 Port: out_inst  output  32  instruction of the head entry.

Function
REQ-015 Two states: IDLE (no fetch outstanding) and WAIT (one fetch outstanding); at most one fetch is outstanding at any time.
REQ-016 inst_start is combinational: 1 iff state==IDLE, inst_ready==1, buffer count < DEPTH, redirect_valid==0 and rst==0.
REQ-017 On an issue cycle: req_pc <= fetch_pc, fetch_pc <= fetch_pc+4 (mod 2^32, wraps 32'hFFFFFFFC to 0), state <= WAIT.
REQ-018 In WAIT, inst_start is 0 and inst_valid is monitored; in IDLE, inst_valid is ignored.
REQ-019 In WAIT with inst_valid==1: push {req_pc, inst} into the buffer unless the discard flag is set or redirect_valid==1; clear the discard flag; state <= IDLE.
REQ-020 Minimum issue-to-issue spacing is 2 cycles; no issue in the same cycle a response is accepted.
REQ-021 Buffer is a FIFO of DEPTH entries; out_valid = (count!=0); out_pc/out_inst show the oldest entry; pop when out_valid && out_ready.
REQ-022 Simultaneous push and pop: count unchanged, order preserved; a push never occurs at count==DEPTH (guaranteed by REQ-016).
REQ-023 Redirect cycle: fetch_pc <= {redirect_pc[31:2],2'b00}, buffer flushed (count <= 0, no pop effect), out_valid becomes 0 next cycle; if state==WAIT and no response this cycle, discard flag <= 1.
REQ-024 Redirect has priority over a simultaneous pop, push or issue.
REQ-025 A discarded response returns the block to IDLE with no buffer change; next issue uses the redirected PC.

Reset
REQ-026 While rst==1: inst_start=0, out_valid=0, state=IDLE, discard flag=0, count=0, fetch_pc=START_ADDR, req_pc=0, out_pc=0, out_inst=0.
REQ-027 Reset mid-fetch abandons the outstanding request; the late response is ignored since state is IDLE and the next issue waits for inst_ready.

Configuration
REQ-028 Macro IFETCH_PREFETCH_EN defined: DEPTH=2, the next fetch issues while one entry awaits decode.
REQ-029 Macro IFETCH_PREFETCH_EN undefined: DEPTH=1, next fetch issues only after the buffer empties; all other behaviour identical.

Verification
REQ-030 Reset release, START_ADDR=0, inst_ready=1, response 2 cycles after issue with 32'h00000013, out_ready=1 -> i_addr 0x0, 0x4, 0x8 in order; out_pc 0x0 with out_inst 32'h00000013 first.
REQ-031 out_ready=0 with prefetch enabled -> exactly 2 fetches (0x0, 0x4), then inst_start stays 0; raising out_ready pops 0x0 then 0x4 and fetching resumes at 0x8.
REQ-032 redirect_valid=1, redirect_pc=32'h00000103 during WAIT for 0x4 -> response for 0x4 dropped, buffer empty, next i_addr = 0x100.
REQ-033 redirect_valid in the same cycle as inst_valid -> response not pushed, next i_addr equals redirect target.
REQ-034 inst_ready=0 for 5 cycles -> inst_start 0 throughout, i_addr held; first cycle inst_ready=1 -> inst_start=1.
REQ-035 rst asserted during WAIT, response arrives during reset -> out_valid stays 0; first fetch after release is START_ADDR.
